// File: rtl/block_transfer_ctrl.sv
// Multi-register load/store sequencer: walks a register list lowest-index-first,
// issuing one memory request per register, with optional base writeback.
module block_transfer_ctrl #(
  parameter int ADDRESS_LEN = 4,
  parameter int SIZE        = 15,
  parameter int DATA_LEN    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   is_load,
  input  logic                   up,
  input  logic                   pre,
  input  logic                   wback,
  input  logic [ADDRESS_LEN-1:0] base_reg,
  input  logic [DATA_LEN-1:0]    base_val,
  input  logic [SIZE-1:0]        reg_list,
  output logic [ADDRESS_LEN-1:0] rf_src,
  input  logic [DATA_LEN-1:0]    rf_rdata,
  output logic                   rf_wb_en,
  output logic [ADDRESS_LEN-1:0] rf_wb_dest,
  output logic [DATA_LEN-1:0]    rf_wb_data,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [DATA_LEN-1:0]    mem_addr,
  output logic [DATA_LEN-1:0]    mem_wdata,
  input  logic [DATA_LEN-1:0]    mem_rdata,
  input  logic                   mem_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, XFER, WBASE, DONE} state_t;

  state_t                 state, state_nx;
  logic [SIZE-1:0]        pend, pend_nx, pend_clr;
  logic [DATA_LEN-1:0]    addr, addr_nx, fbase;
  logic                   load_q, wback_q;
  logic [ADDRESS_LEN-1:0] breg_q;
  logic [DATA_LEN-1:0]    cnt, four_n, start_addr;
  logic [ADDRESS_LEN-1:0] cur_idx;
  logic                   found;

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < SIZE; i++)
      cnt = cnt + DATA_LEN'(reg_list[i]);
    four_n = cnt << 2;
    // Words are always transferred at ascending addresses; only the start differs.
    case ({up, pre})
      2'b10:   start_addr = base_val;
      2'b11:   start_addr = base_val + DATA_LEN'(4);
      2'b00:   start_addr = base_val - four_n + DATA_LEN'(4);
      default: start_addr = base_val - four_n;
    endcase
  end

  always_comb begin
    found   = 1'b0;
    cur_idx = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (pend[i] && !found) begin
        cur_idx = ADDRESS_LEN'(i);
        found   = 1'b1;
      end
    end
    pend_clr = pend & (pend - SIZE'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pend    <= '0;
      addr    <= '0;
      fbase   <= '0;
      load_q  <= 1'b0;
      wback_q <= 1'b0;
      breg_q  <= '0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
      addr  <= addr_nx;
      if (state == IDLE && start) begin
        load_q  <= is_load;
        wback_q <= wback;
        breg_q  <= base_reg;
        fbase   <= up ? base_val + four_n : base_val - four_n;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    pend_nx    = pend;
    addr_nx    = addr;
    rf_src     = '0;
    rf_wb_en   = 1'b0;
    rf_wb_dest = '0;
    rf_wb_data = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pend_nx = reg_list;
          addr_nx = start_addr;
          if (reg_list != '0)
            state_nx = XFER;
          else
            state_nx = wback ? WBASE : DONE;
        end
      end
      XFER: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = ~load_q;
        mem_addr  = addr;
        rf_src    = cur_idx;
        mem_wdata = rf_rdata;
        if (mem_ready) begin
          if (load_q) begin
            rf_wb_en   = 1'b1;
            rf_wb_dest = cur_idx;
            rf_wb_data = mem_rdata;
          end
          pend_nx = pend_clr;
          addr_nx = addr + DATA_LEN'(4);
          if (pend_clr == '0)
            state_nx = wback_q ? WBASE : DONE;
        end
      end
      WBASE: begin
        busy       = 1'b1;
        rf_wb_en   = 1'b1;
        rf_wb_dest = breg_q;
        rf_wb_data = fbase;
        state_nx   = DONE;
      end
      default: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_block_transfer_ctrl.sv
// Directed and randomized checks of block_transfer_ctrl against a transaction-level
// model: expected address/register sequence, register file contents and latency.
module tb_block_transfer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, is_load = 1'b0, up = 1'b0, pre = 1'b0, wback = 1'b0;
  logic [3:0]  base_reg = '0;
  logic [31:0] base_val = '0;
  logic [14:0] reg_list = '0;
  logic [3:0]  rf_src, rf_wb_dest;
  logic [31:0] rf_rdata, rf_wb_data, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        rf_wb_en, mem_req, mem_we, busy, done;

  logic [31:0] rf_env [15] = '{default: '0};
  logic [31:0] ref_rf [15] = '{default: '0};
  int checks = 0;
  int errors = 0;

  block_transfer_ctrl #(.ADDRESS_LEN(4), .SIZE(15), .DATA_LEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .up(up), .pre(pre),
    .wback(wback), .base_reg(base_reg), .base_val(base_val), .reg_list(reg_list),
    .rf_src(rf_src), .rf_rdata(rf_rdata), .rf_wb_en(rf_wb_en), .rf_wb_dest(rf_wb_dest),
    .rf_wb_data(rf_wb_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Register file environment: combinational read, commit on the falling edge.
  assign rf_rdata = (rf_src < 4'd15) ? rf_env[rf_src] : '0;
  always @(negedge clk)
    if (rf_wb_en && rf_wb_dest < 4'd15) rf_env[rf_wb_dest] <= rf_wb_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".mem_req"}, 32'(mem_req), 0);
    chk({tag, ".mem_we"}, 32'(mem_we), 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".rf_src"}, 32'(rf_src), 0);
    chk({tag, ".rf_wb_en"}, 32'(rf_wb_en), 0);
    chk({tag, ".rf_wb_dest"}, 32'(rf_wb_dest), 0);
    chk({tag, ".rf_wb_data"}, rf_wb_data, 0);
  endtask

  task automatic noise_inputs();
    start    = 1'($urandom_range(1, 0));
    is_load  = 1'($urandom_range(1, 0));
    up       = 1'($urandom_range(1, 0));
    pre      = 1'($urandom_range(1, 0));
    wback    = 1'($urandom_range(1, 0));
    base_reg = 4'($urandom_range(14, 0));
    base_val = $urandom;
    reg_list = 15'($urandom);
  endtask

  // One complete operation, called from just after a rising edge while IDLE.
  task automatic run_op(input string tag, input logic ld, input logic up_i, input logic pre_i,
                        input logic wb, input logic [3:0] breg, input logic [31:0] base,
                        input logic [14:0] list, input int wait_first, input int ready_pct,
                        input bit noise);
    int unsigned idxq[$];
    int          n, j, w;
    logic [31:0] a0, fin, ea;
    logic        rdy;
    for (int i = 0; i < 15; i++) if (list[i]) idxq.push_back(i);
    n   = idxq.size();
    fin = up_i ? base + 32'(4 * n) : base - 32'(4 * n);
    if (up_i) a0 = pre_i ? base + 32'd4 : base;
    else      a0 = pre_i ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
    is_load = ld; up = up_i; pre = pre_i; wback = wb; base_reg = breg;
    base_val = base; reg_list = list; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    j = 0;
    w = wait_first;
    while (j < n) begin
      rdy = (w > 0) ? 1'b0 : ($urandom_range(99, 0) < ready_pct);
      if (w > 0) w--;
      mem_ready = rdy;
      mem_rdata = $urandom;
      if (noise) noise_inputs();
      @(negedge clk);
      ea = a0 + 32'(4 * j);
      chk({tag, ".busy"}, 32'(busy), 1);
      chk({tag, ".done"}, 32'(done), 0);
      chk({tag, ".mem_req"}, 32'(mem_req), 1);
      chk({tag, ".mem_we"}, 32'(mem_we), 32'(!ld));
      chk({tag, ".mem_addr"}, mem_addr, ea);
      chk({tag, ".rf_src"}, 32'(rf_src), idxq[j]);
      if (!ld) chk({tag, ".mem_wdata"}, mem_wdata, ref_rf[idxq[j]]);
      chk({tag, ".rf_wb_en"}, 32'(rf_wb_en), 32'(ld && rdy));
      if (ld && rdy) begin
        chk({tag, ".rf_wb_dest"}, 32'(rf_wb_dest), idxq[j]);
        chk({tag, ".rf_wb_data"}, rf_wb_data, mem_rdata);
        ref_rf[idxq[j]] = mem_rdata;
      end
      if (rdy) j++;
      @(posedge clk); #1;
    end
    mem_ready = 1'($urandom_range(1, 0));
    if (noise) noise_inputs();
    if (wb) begin
      @(negedge clk);
      chk({tag, ".wb.busy"}, 32'(busy), 1);
      chk({tag, ".wb.done"}, 32'(done), 0);
      chk({tag, ".wb.mem_req"}, 32'(mem_req), 0);
      chk({tag, ".wb.rf_wb_en"}, 32'(rf_wb_en), 1);
      chk({tag, ".wb.rf_wb_dest"}, 32'(rf_wb_dest), 32'(breg));
      chk({tag, ".wb.rf_wb_data"}, rf_wb_data, fin);
      ref_rf[breg] = fin;
      @(posedge clk); #1;
      if (noise) noise_inputs();
    end
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".done.busy"}, 32'(busy), 1);
    chk({tag, ".done.mem_req"}, 32'(mem_req), 0);
    chk({tag, ".done.rf_wb_en"}, 32'(rf_wb_en), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk_idle({tag, ".after"});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] d;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_idle("idle");
    @(posedge clk); #1;

    run_op("preload", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h1000, 15'h7FFF, 0, 70, 1'b0);
    run_op("ia_store", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h100, 15'h0005, 0, 100, 1'b0);
    run_op("db_load_wb", 1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h200, 15'h002A, 0, 100, 1'b0);
    run_op("wait_store", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h300, 15'h0012, 3, 100, 1'b0);
    run_op("empty_wb", 1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 32'h80, 15'h0000, 0, 100, 1'b0);
    run_op("full_wrap", 1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'hFFFFFFF8, 15'h7FFF, 0, 80, 1'b0);
    run_op("da_store", 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 32'h40, 15'h4301, 1, 70, 1'b0);

    // Abort a load of R1,R3,R5 during its second transfer.
    is_load = 1'b1; up = 1'b1; pre = 1'b0; wback = 1'b1; base_reg = 4'd2;
    base_val = 32'h400; reg_list = 15'h002A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mem_ready = 1'b1; d = $urandom; mem_rdata = d;
    @(negedge clk);
    chk("abort.x1.addr", mem_addr, 32'h400);
    chk("abort.x1.dest", 32'(rf_wb_dest), 1);
    chk("abort.x1.data", rf_wb_data, d);
    ref_rf[1] = d;
    @(posedge clk); #1;
    mem_rdata = $urandom;
    #2 rst = 1'b0;
    #1 chk_idle("abort");
    repeat (3) begin
      @(negedge clk);
      chk_idle("abort.hold");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_idle("abort.release");
    @(posedge clk); #1;
    run_op("post_abort", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h500, 15'h002A, 0, 100, 1'b0);

    for (int t = 0; t < 20; t++)
      run_op("rand", 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             4'($urandom_range(14, 0)), $urandom, 15'($urandom),
             $urandom_range(2, 0), 60, 1'b1);

    for (int i = 0; i < 15; i++)
      chk($sformatf("regfile[%0d]", i), rf_env[i], ref_rf[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
